// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART state codes and line levels (PARITY code under UART_FIFO_TX_PARITY_EN)
package uart_defs;

    localparam logic [2:0] UART_ST_IDLE   = 3'd0;
    localparam logic [2:0] UART_ST_LOAD   = 3'd1;
    localparam logic [2:0] UART_ST_START  = 3'd2;
    localparam logic [2:0] UART_ST_DATA   = 3'd3;
    localparam logic [2:0] UART_ST_STOP   = 3'd4;
`ifdef UART_FIFO_TX_PARITY_EN
    localparam logic [2:0] UART_ST_PARITY = 3'd5;
`endif

    localparam logic UART_LINE_IDLE  = 1'b1;
    localparam logic UART_LINE_START = 1'b0;

endpackage

// File: rtl/uart_fifo_tx_pkg.sv
// rtl/uart_fifo_tx_pkg.sv - transmitter state type and parity helper (UART_FIFO_TX_PARITY_EN)
package uart_fifo_tx_pkg;

    import uart_defs::*;

    typedef enum logic [2:0] {
        S_IDLE   = UART_ST_IDLE,
        S_LOAD   = UART_ST_LOAD,
        S_START  = UART_ST_START,
        S_DATA   = UART_ST_DATA,
        S_STOP   = UART_ST_STOP
`ifdef UART_FIFO_TX_PARITY_EN
        ,
        S_PARITY = UART_ST_PARITY
`endif
    } tx_state_t;

`ifdef UART_FIFO_TX_PARITY_EN
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction
`endif

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter, ticks on the last clock of each bit
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Wraps on its own at the terminal count so consecutive data bits need no clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - UART transmitter draining an external FIFO (optional parity: UART_FIFO_TX_PARITY_EN)
module uart_fifo_tx
    import uart_defs::*;
    import uart_fifo_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  in_clock,
    input  logic                  in_reset,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_take,
    output logic                  out_tx,
    output logic                  out_busy
);

    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    tx_state_t             state;
    tx_state_t             next_state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [IDX_W-1:0]      idx;
    logic                  tick;
    logic                  baud_clear;
    logic                  load_en;
    logic                  shift_en;
    logic                  next_tx;
`ifdef UART_FIFO_TX_PARITY_EN
    logic                  parity_bit;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (in_clock),
        .resetn (in_reset),
        .clear  (baud_clear),
        .tick   (tick)
    );

    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!in_empty) begin
                    next_state = S_LOAD;
                    load_en    = 1'b1;
                end
            end
            S_LOAD:  next_state = S_START;
            S_START: if (tick) next_state = S_DATA;
            S_DATA: begin
                if (tick) begin
                    if (idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_FIFO_TX_PARITY_EN
                        next_state = S_PARITY;
`else
                        next_state = S_STOP;
`endif
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
`ifdef UART_FIFO_TX_PARITY_EN
            S_PARITY: if (tick) next_state = S_STOP;
`endif
            S_STOP:  if (tick) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Line level is precomputed from the next state so out_tx leaves a flop.
    always_comb begin
        next_tx = UART_LINE_IDLE;
        case (next_state)
            S_START:  next_tx = UART_LINE_START;
            S_DATA:   next_tx = shift_en ? shreg[1] : shreg[0];
`ifdef UART_FIFO_TX_PARITY_EN
            S_PARITY: next_tx = parity_bit;
`endif
            default:  next_tx = UART_LINE_IDLE;
        endcase
    end

    assign baud_clear = (next_state != state) || (state == S_IDLE) || (state == S_LOAD);

    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            state    <= S_IDLE;
            shreg    <= '0;
            idx      <= '0;
            out_tx   <= UART_LINE_IDLE;
            out_take <= 1'b0;
            out_busy <= 1'b0;
        end else begin
            state    <= next_state;
            out_tx   <= next_tx;
            out_take <= load_en;
            out_busy <= (next_state != S_IDLE);
            if (load_en) begin
                shreg <= in_data;
            end else if (shift_en) begin
                shreg <= shreg >> 1;
            end
            if (next_state != state) begin
                idx <= '0;
            end else if (shift_en) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef UART_FIFO_TX_PARITY_EN
    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            parity_bit <= 1'b0;
        end else if (load_en) begin
            parity_bit <= even_parity(64'(in_data));
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb/tb_uart_fifo_tx.sv - directed bench for uart_fifo_tx (UART_FIFO_TX_PARITY_EN adds the parity bit)
module tb_uart_fifo_tx;

    localparam int DW  = 8;
    localparam int CPB = 4;
`ifdef UART_FIFO_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    typedef struct {
        logic [7:0] word;
        logic [0:9] bits;
        logic       par;
    } vec_t;

    logic          clk;
    logic          in_reset;
    logic          in_empty;
    logic [DW-1:0] in_data;
    logic          out_take;
    logic          out_tx;
    logic          out_busy;

    logic [7:0] fifo_mem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         take_cnt = 0;
    logic       bad_take = 1'b0;
    int         vectors = 0;
    int         errors = 0;
    vec_t       tbl [6];

    uart_fifo_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .in_clock (clk),
        .in_reset (in_reset),
        .in_empty (in_empty),
        .in_data  (in_data),
        .out_take (out_take),
        .out_tx   (out_tx),
        .out_busy (out_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign in_empty = (rd_ptr == wr_ptr);
    assign in_data  = fifo_mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (out_take && in_empty) bad_take <= 1'b1;
        if (out_take && !in_empty) rd_ptr <= rd_ptr + 1;
        if (out_take) take_cnt <= take_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int b);
`ifdef UART_FIFO_TX_PARITY_EN
        if (b == 9) return v.par;
        if (b == 10) return v.bits[9];
`endif
        return v.bits[b];
    endfunction

    task automatic push(input logic [7:0] w);
        fifo_mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_take();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_take) seen = 1'b1;
        end
        chk("take_seen", 32'(seen), 32'd1);
    endtask

    // Entered at the LOAD-cycle sample; leaves at the IDLE-cycle sample after STOP.
    task automatic frame_body(input vec_t v);
        chk("load_take", 32'(out_take), 32'd1);
        chk("load_tx", 32'(out_tx), 32'd1);
        chk("load_busy", 32'(out_busy), 32'd1);
        for (int b = 0; b < FB; b++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                chk($sformatf("bit%0d_w%0h", b, v.word), 32'(out_tx), 32'(exp_bit(v, b)));
                chk("frame_busy", 32'(out_busy), 32'd1);
                chk("frame_take", 32'(out_take), 32'd0);
            end
        end
        @(negedge clk);
        chk("idle_tx", 32'(out_tx), 32'd1);
        chk("idle_busy", 32'(out_busy), 32'd0);
    endtask

    initial begin
        int t0;
        tbl[0] = '{word: 8'hA5, bits: 10'b0101001011, par: 1'b0};
        tbl[1] = '{word: 8'h00, bits: 10'b0000000001, par: 1'b0};
        tbl[2] = '{word: 8'hFF, bits: 10'b0111111111, par: 1'b0};
        tbl[3] = '{word: 8'h3C, bits: 10'b0001111001, par: 1'b0};
        tbl[4] = '{word: 8'h07, bits: 10'b0111000001, par: 1'b1};
        tbl[5] = '{word: 8'h03, bits: 10'b0110000001, par: 1'b0};

        in_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_tx", 32'(out_tx), 32'd1);
            chk("rst_take", 32'(out_take), 32'd0);
            chk("rst_busy", 32'(out_busy), 32'd0);
        end
        in_reset = 1'b1;

        for (int k = 0; k < 6; k++) begin
            t0 = take_cnt;
            push(tbl[k].word);
            wait_take();
            frame_body(tbl[k]);
            chk("one_take", 32'(take_cnt - t0), 32'd1);
        end

        // Back-to-back: exactly one IDLE and one LOAD high cycle between frames.
        t0 = take_cnt;
        push(8'h00);
        push(8'hFF);
        wait_take();
        frame_body(tbl[1]);
        @(negedge clk);
        chk("b2b_gap_take", 32'(out_take), 32'd1);
        frame_body(tbl[2]);
        chk("b2b_takes", 32'(take_cnt - t0), 32'd2);
        chk("b2b_empty", 32'(in_empty), 32'd1);

        // Reset mid-frame aborts and discards the popped word.
        push(8'h3C);
        wait_take();
        repeat (12) @(negedge clk);
        chk("mid_tx_low", 32'(out_tx), 32'(exp_bit(tbl[3], 2)));
        in_reset = 1'b0;
        @(negedge clk);
        chk("abort_tx", 32'(out_tx), 32'd1);
        chk("abort_busy", 32'(out_busy), 32'd0);
        chk("abort_take", 32'(out_take), 32'd0);
        in_reset = 1'b1;
        t0 = take_cnt;
        repeat (20) @(negedge clk);
        chk("post_abort_takes", 32'(take_cnt - t0), 32'd0);
        chk("post_abort_tx", 32'(out_tx), 32'd1);

        t0 = take_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("empty_tx", 32'(out_tx), 32'd1);
        end
        chk("empty_takes", 32'(take_cnt - t0), 32'd0);
        chk("take_while_empty", 32'(bad_take), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
